pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, flow-controlled pipeline stage register. It replaces fixed stage registers such as the MEM/WB stage.
- Carries a generic payload plus writeback control (rd, regwrite, mem_to_reg) with valid/ready handshake, optional 2-entry skid buffer, synchronous flush and a saturating stall counter.
- Sits between any two pipeline stages. Drop-in for IF/ID, ID/EX, EX/MEM and MEM/WB by setting PAYLOAD_W.

Parameters:
- PAYLOAD_W, 64: width of the opaque payload, e.g. two 32-bit ALU results.
- RD_W, 5: destination register index width.
- SKID_EN, 1: 1 = registered in_ready with a skid slot; 0 = single slot with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous reset, active-high; clears all state immediately
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_payload  in  PAYLOAD_W  upstream data
- in_rd  in  RD_W  destination register
- in_regwrite  in  1  register write enable
- in_mem_to_reg  in  1  writeback source select
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts this cycle
- out_payload  out  PAYLOAD_W  head data
- out_rd  out  RD_W  head destination
- out_regwrite  out  1  head write enable
- out_mem_to_reg  out  1  head source select
- stall_cnt  out  CNT_W  saturating count of backpressured cycles
- stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Clock and reset: one clock `clk`, posedge. `rst` is asynchronous and active-high; it clears every register without waiting for a clock edge.
- Handshakes: input accept = in_valid & in_ready; output accept = out_valid & out_ready. Latency is 1 cycle from input accept to out_valid.
- Reset values: out_valid=0, all out_* = 0, stall_cnt=0, state=EMPTY. in_ready=0 while rst is high, and 1 on the first cycle after release.
- Bubble safety: whenever out_valid=0, out_payload, out_rd, out_regwrite and out_mem_to_reg read 0. A bubble must never write the register file.
- State machine when SKID_EN=1 (main slot plus skid slot); in_ready = !skid_valid, registered:
  - EMPTY: in accept -> ONE, main <= in.
  - ONE, in accept and out accept -> ONE, main <= in.
  - ONE, in accept only -> TWO, skid <= in.
  - ONE, out accept only -> EMPTY.
  - ONE, neither -> hold.
  - TWO: in_ready=0. Out accept -> ONE, main <= skid, skid cleared; otherwise hold.
- SKID_EN=0: single slot. in_ready = !main_valid | out_ready (combinational). States are EMPTY and ONE only, with the same transitions.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- Flush: highest priority after reset. On the next edge the state goes to EMPTY, held entries are dropped, and an entry accepted in the flush cycle is discarded. A downstream out accept in the flush cycle still counts as delivered. in_ready follows the normal rule during flush.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready; saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment.
  - Not affected by flush.
- No combinational path from in_* to out_*. With SKID_EN=1 there is also no out_ready -> in_ready path.

Decomposition:
- Shared package pipe_pkg:
  - State enum `pipe_state_t` {EMPTY, ONE, TWO}.
  - Constants XLEN=32, REG_ADDR_W=5.
  - Struct `wb_ctrl_t` {rd, regwrite, mem_to_reg}.
- One sub-module: sat_counter (parametrised width, inc, clr, async reset), reused for other performance counters.

Test Plan:
- Reset mid-operation: rst high while in TWO -> out_valid=0 and outputs 0 immediately, without a clock edge; in_ready=1 on the first cycle after release.
- Streaming: out_ready=1, send payload 0x1..0x8 with rd=1..8 on back-to-back cycles -> identical sequence out, 1-cycle latency, in_ready stays 1.
- Backpressure (SKID_EN=1): out_ready=0 with 3 inputs offered -> first two held, in_ready=0 after the 2nd, 3rd not accepted. Then out_ready=1 -> order 1,2,3; stall_cnt equals the number of stalled cycles.
- Flush: flush in TWO with in_valid=1, rd=7, regwrite=1 -> next cycle out_valid=0, out_regwrite=0; that entry never appears.
- Counter saturation: CNT_W=4, 20 stalled cycles -> stall_cnt=15. stall_clr together with a stall -> stall_cnt=0.
- SKID_EN=0: out_ready=0 while full -> in_ready=0 in the same cycle. Raising out_ready -> in_ready=1 in the same cycle, and the entry is replaced on the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage-register occupancy states and writeback control bundle.
package pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  mem_to_reg;
   } wb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional skid slot, flush and stall counter.
// Outputs come only from flops; with SKID_EN=1 in_ready is also free of any out_ready path.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 2*XLEN,
   parameter int RD_W      = REG_ADDR_W,
   parameter int SKID_EN   = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [RD_W-1:0]      in_rd,
   input  logic                 in_regwrite,
   input  logic                 in_mem_to_reg,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [RD_W-1:0]      out_rd,
   output logic                 out_regwrite,
   output logic                 out_mem_to_reg,
   output logic [CNT_W-1:0]     stall_cnt,
   input  logic                 stall_clr
);

   pipe_state_t          state_q, state_d;

   logic [PAYLOAD_W-1:0] main_pay_q, main_pay_d;
   logic [RD_W-1:0]      main_rd_q,  main_rd_d;
   logic                 main_rw_q,  main_rw_d;
   logic                 main_m2r_q, main_m2r_d;

   logic [PAYLOAD_W-1:0] skid_pay_q, skid_pay_d;
   logic [RD_W-1:0]      skid_rd_q,  skid_rd_d;
   logic                 skid_rw_q,  skid_rw_d;
   logic                 skid_m2r_q, skid_m2r_d;

   logic                 in_acc;
   logic                 out_acc;

   // Skid mode: ready depends only on occupancy, so it is effectively a flop output.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (SKID_EN != 0) begin
            in_ready = (state_q != TWO);
         end else begin
            in_ready = (state_q == EMPTY) || out_ready;
         end
      end
   end

   assign out_valid = (state_q != EMPTY);
   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;

   // Bubbles present all-zero control so they can never write the register file.
   assign out_payload    = out_valid ? main_pay_q : '0;
   assign out_rd         = out_valid ? main_rd_q  : '0;
   assign out_regwrite   = out_valid && main_rw_q;
   assign out_mem_to_reg = out_valid && main_m2r_q;

   always_comb begin
      state_d    = state_q;
      main_pay_d = main_pay_q;
      main_rd_d  = main_rd_q;
      main_rw_d  = main_rw_q;
      main_m2r_d = main_m2r_q;
      skid_pay_d = skid_pay_q;
      skid_rd_d  = skid_rd_q;
      skid_rw_d  = skid_rw_q;
      skid_m2r_d = skid_m2r_q;

      if (flush) begin
         state_d    = EMPTY;
         main_pay_d = '0;
         main_rd_d  = '0;
         main_rw_d  = 1'b0;
         main_m2r_d = 1'b0;
         skid_pay_d = '0;
         skid_rd_d  = '0;
         skid_rw_d  = 1'b0;
         skid_m2r_d = 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_acc) begin
                  state_d    = ONE;
                  main_pay_d = in_payload;
                  main_rd_d  = in_rd;
                  main_rw_d  = in_regwrite;
                  main_m2r_d = in_mem_to_reg;
               end
            end
            ONE: begin
               if (in_acc && out_acc) begin
                  main_pay_d = in_payload;
                  main_rd_d  = in_rd;
                  main_rw_d  = in_regwrite;
                  main_m2r_d = in_mem_to_reg;
               end else if (in_acc) begin
                  // Unreachable without a skid slot: in_acc in ONE implies out_ready.
                  if (SKID_EN != 0) begin
                     state_d    = TWO;
                     skid_pay_d = in_payload;
                     skid_rd_d  = in_rd;
                     skid_rw_d  = in_regwrite;
                     skid_m2r_d = in_mem_to_reg;
                  end
               end else if (out_acc) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_acc) begin
                  state_d    = ONE;
                  main_pay_d = skid_pay_q;
                  main_rd_d  = skid_rd_q;
                  main_rw_d  = skid_rw_q;
                  main_m2r_d = skid_m2r_q;
                  skid_pay_d = '0;
                  skid_rd_d  = '0;
                  skid_rw_d  = 1'b0;
                  skid_m2r_d = 1'b0;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_pay_q <= '0;
         main_rd_q  <= '0;
         main_rw_q  <= 1'b0;
         main_m2r_q <= 1'b0;
         skid_pay_q <= '0;
         skid_rd_q  <= '0;
         skid_rw_q  <= 1'b0;
         skid_m2r_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_pay_q <= main_pay_d;
         main_rd_q  <= main_rd_d;
         main_rw_q  <= main_rw_d;
         main_m2r_q <= main_m2r_d;
         skid_pay_q <= skid_pay_d;
         skid_rd_q  <= skid_rd_d;
         skid_rw_q  <= skid_rw_d;
         skid_m2r_q <= skid_m2r_d;
      end
   end

   // Flush deliberately does not touch the stall statistics.
   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (out_valid && !out_ready),
      .clr_i (stall_clr),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid instance (4-bit counter) and a single-slot instance from shared stimulus;
// per-instance queues model the stage as a bounded FIFO.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [63:0] p;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_payload;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        in_mem_to_reg;
   logic        out_ready;
   logic        stall_clr;

   logic        in_ready_a, out_valid_a, out_rw_a, out_m2r_a;
   logic [63:0] out_pay_a;
   logic [4:0]  out_rd_a;
   logic [3:0]  stall_cnt_a;

   logic        in_ready_b, out_valid_b, out_rw_b, out_m2r_b;
   logic [63:0] out_pay_b;
   logic [4:0]  out_rd_b;
   logic [15:0] stall_cnt_b;

   ent_t qa[$];
   ent_t qb[$];
   int   cnta, cntb;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(64), .RD_W(5), .SKID_EN(1), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_payload(in_payload), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_mem_to_reg(in_mem_to_reg),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_payload(out_pay_a), .out_rd(out_rd_a),
      .out_regwrite(out_rw_a), .out_mem_to_reg(out_m2r_a),
      .stall_cnt(stall_cnt_a), .stall_clr(stall_clr)
   );

   pipe_stage_reg #(.PAYLOAD_W(64), .RD_W(5), .SKID_EN(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_payload(in_payload), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_mem_to_reg(in_mem_to_reg),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_payload(out_pay_b), .out_rd(out_rd_b),
      .out_regwrite(out_rw_b), .out_mem_to_reg(out_m2r_b),
      .stall_cnt(stall_cnt_b), .stall_clr(stall_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: output of the stage must match the head of the reference queue.
   task automatic mon_one(input string t, input int which, input logic v, input logic [63:0] p,
                          input logic [4:0] rd, input logic rw, input logic m2r, input logic [15:0] cnt);
      ent_t e;
      int   sz;
      int   ecnt;
      sz   = (which == 0) ? qa.size() : qb.size();
      ecnt = (which == 0) ? cnta : cntb;
      chk({t, "_out_valid"}, 64'(v), 64'(sz != 0));
      chk({t, "_stall_cnt"}, 64'(cnt), 64'(ecnt));
      if (v && out_ready && sz != 0) begin
         if (which == 0) e = qa.pop_front();
         else            e = qb.pop_front();
         chk({t, "_payload"}, p, e.p);
         chk({t, "_rd"}, 64'(rd), 64'(e.rd));
         chk({t, "_regwrite"}, 64'(rw), 64'(e.rw));
         chk({t, "_mem_to_reg"}, 64'(m2r), 64'(e.m2r));
      end else if (!v) begin
         chk({t, "_bubble_payload"}, p, 64'd0);
         chk({t, "_bubble_ctrl"}, 64'({rd, rw, m2r}), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         mon_one("a", 0, out_valid_a, out_pay_a, out_rd_a, out_rw_a, out_m2r_a, {12'd0, stall_cnt_a});
         mon_one("b", 1, out_valid_b, out_pay_b, out_rd_b, out_rw_b, out_m2r_b, stall_cnt_b);
      end
   end

   // One clock of stimulus; the model decides acceptance from queue occupancy alone.
   task automatic cycle(input logic v, input logic [63:0] p, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic ordy, input logic fl, input logic clr,
                        output logic acc_a);
      logic era, erb, va, vb;
      ent_t e;
      @(negedge clk);
      in_valid = v; in_payload = p; in_rd = rd; in_regwrite = rw; in_mem_to_reg = m2r;
      out_ready = ordy; flush = fl; stall_clr = clr;
      va  = (qa.size() != 0);
      vb  = (qb.size() != 0);
      era = (qa.size() < 2);
      erb = (qb.size() == 0) || ordy;
      #2;
      chk("a_in_ready", 64'(in_ready_a), 64'(era));
      chk("b_in_ready", 64'(in_ready_b), 64'(erb));
      e = '{p: p, rd: rd, rw: rw, m2r: m2r};
      acc_a = v && era;
      if (fl) begin
         qa.delete();
         qb.delete();
      end else begin
         if (v && era) qa.push_back(e);
         if (v && erb) qb.push_back(e);
      end
      if (clr) cnta = 0; else if (va && !ordy && cnta != 15) cnta++;
      if (clr) cntb = 0; else if (vb && !ordy && cntb != 65535) cntb++;
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b0, acc);
   endtask

   initial begin
      logic acc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_rd = '0;
      in_regwrite = 1'b0; in_mem_to_reg = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
      cnta = 0; cntb = 0;
      #1;
      chk("rst_a_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_b_out_valid", 64'(out_valid_b), 64'd0);
      chk("rst_a_in_ready", 64'(in_ready_a), 64'd0);
      chk("rst_b_in_ready", 64'(in_ready_b), 64'd0);
      chk("rst_a_stall_cnt", 64'(stall_cnt_a), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Streaming: 1..8 back to back with downstream always ready.
      for (int i = 1; i <= 8; i++)
         cycle(1'b1, 64'(i), 5'(i), 1'b1, i[0], 1'b1, 1'b0, 1'b0, acc);
      repeat (2) idle(1'b1);

      // Backpressure: three offers while stalled, third must wait for space.
      cycle(1'b1, 64'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h12, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h13, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 64'h13, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
         if (acc) break;
      end
      repeat (3) idle(1'b1);

      // Flush while the skid instance holds two entries and a write is offered.
      cycle(1'b1, 64'h21, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h22, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h77, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      idle(1'b0);
      chk("flush_a_out_regwrite", 64'(out_rw_a), 64'd0);
      repeat (2) idle(1'b1);

      // Counter saturation and clear-over-increment.
      cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b1, 64'h31, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      repeat (21) idle(1'b0);
      chk("sat_a_stall_cnt", 64'(stall_cnt_a), 64'd15);
      cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      idle(1'b0);
      chk("clr_a_stall_cnt", 64'(stall_cnt_a), 64'd0);

      // Single-slot instance is full: ready must follow out_ready in the same cycle.
      cycle(1'b1, 64'h41, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h42, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      chk("nskid_b_in_ready", 64'(in_ready_b), 64'd1);
      repeat (3) idle(1'b1);

      // Asynchronous reset while the skid instance is in its two-entry state.
      cycle(1'b1, 64'h51, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 64'h52, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      #3 rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("arst_a_out_valid", 64'(out_valid_a), 64'd0);
      chk("arst_a_out_payload", out_pay_a, 64'd0);
      chk("arst_a_out_ctrl", 64'({out_rd_a, out_rw_a, out_m2r_a}), 64'd0);
      chk("arst_a_in_ready", 64'(in_ready_a), 64'd0);
      qa.delete(); qb.delete(); cnta = 0; cntb = 0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      idle(1'b1);

      // Randomised traffic.
      for (int n = 0; n < 500; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0), acc);
      end
      repeat (4) idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
